// File: rtl/mips_mem_access_unit.sv
// Load/store unit between the MIPS execute stage and a word-organised data RAM.
// Handles big-endian byte swapping, sub-word loads, LWL/LWR merging and RMW sub-word stores.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | req_ready high, waiting for req_valid
// S_ACCESS | RAM read (loads, SB/SH) or RAM write (SW)
// S_RMW_WR | write back the merged word of an SB/SH
// S_RESP   | resp_valid pulse, then back to S_IDLE
module mips_mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter bit RMW_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_rt,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] data_address,
  output logic              data_read,
  output logic              data_write,
  output logic [31:0]       data_writedata,
  input  logic [31:0]       data_readdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RMW_WR = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  function automatic logic [31:0] swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  state_t              r_state;
  state_t              w_next_state;
  logic [3:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rt;
  logic [31:0]         r_merge;
  logic [31:0]         r_resp_rdata;
  logic                r_resp_err;

  logic                w_req_err;
  logic                w_accept;
  logic                w_is_load;
  logic                w_is_sub_store;
  logic [1:0]          w_k;
  logic [4:0]          w_sh_k;
  logic [4:0]          w_sh_inv;
  logic [4:0]          w_sh_half;
  logic [31:0]         w_mem_core;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load_result;
  logic [31:0]         w_merge;

  // Error requests never enter S_ACCESS, so no RAM strobe is raised for them.
  always_comb begin
    w_req_err = 1'b0;
    case (req_op)
      OP_LB, OP_LBU, OP_LWL, OP_LWR: w_req_err = 1'b0;
      OP_LH, OP_LHU:                 w_req_err = req_addr[0];
      OP_LW, OP_SW:                  w_req_err = |req_addr[1:0];
      OP_SB:                         w_req_err = !RMW_EN;
      OP_SH:                         w_req_err = req_addr[0] || !RMW_EN;
      default:                       w_req_err = 1'b1;
    endcase
  end

  assign w_accept       = (r_state == S_IDLE) && req_valid;
  assign w_is_load      = !r_op[3];
  assign w_is_sub_store = (r_op == OP_SB) || (r_op == OP_SH);

  // Byte at offset k sits at bit 31-8k of the core-order word.
  assign w_mem_core = swap32(data_readdata);
  assign w_k        = r_addr[1:0];
  assign w_sh_k     = {w_k, 3'b000};
  assign w_sh_inv   = {~w_k, 3'b000};
  assign w_sh_half  = {~w_k[1], 4'b0000};
  assign w_byte     = 8'(w_mem_core >> w_sh_inv);
  assign w_half     = 16'(w_mem_core >> w_sh_half);

  always_comb begin
    w_load_result = 32'h0;
    case (r_op)
      OP_LB:   w_load_result = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_result = {24'h0, w_byte};
      OP_LH:   w_load_result = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_result = {16'h0, w_half};
      OP_LW:   w_load_result = w_mem_core;
      OP_LWL:  w_load_result = (w_mem_core << w_sh_k)
                             | (r_rt & ~(32'hFFFF_FFFF << w_sh_k));
      OP_LWR:  w_load_result = (w_mem_core >> w_sh_inv)
                             | (r_rt & ~(32'hFFFF_FFFF >> w_sh_inv));
      default: w_load_result = 32'h0;
    endcase
  end

  always_comb begin
    w_merge = w_mem_core;
    if (r_op == OP_SB) begin
      w_merge = (w_mem_core & ~(32'h0000_00FF << w_sh_inv))
              | ({24'h0, r_wdata[7:0]} << w_sh_inv);
    end else if (r_op == OP_SH) begin
      w_merge = (w_mem_core & ~(32'h0000_FFFF << w_sh_half))
              | ({16'h0, r_wdata[15:0]} << w_sh_half);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Strobes are decoded from state so reset kills an in-flight write at once.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    data_read    = 1'b0;
    data_write   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next_state = w_req_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_op == OP_SW) begin
          data_write   = 1'b1;
          w_next_state = S_RESP;
        end else if (w_is_sub_store) begin
          data_read    = 1'b1;
          w_next_state = S_RMW_WR;
        end else begin
          data_read    = 1'b1;
          w_next_state = S_RESP;
        end
      end
      S_RMW_WR: begin
        data_write   = 1'b1;
        w_next_state = S_RESP;
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op         <= 4'h0;
      r_addr       <= '0;
      r_wdata      <= 32'h0;
      r_rt         <= 32'h0;
      r_merge      <= 32'h0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_rt    <= req_rt;
        if (w_req_err) begin
          r_resp_err   <= 1'b1;
          r_resp_rdata <= 32'h0;
        end
      end
      if (r_state == S_ACCESS) begin
        r_resp_err   <= 1'b0;
        r_resp_rdata <= w_is_load ? w_load_result : 32'h0;
        r_merge      <= w_merge;
      end
    end
  end

  assign resp_rdata     = r_resp_rdata;
  assign resp_err       = r_resp_err;
  assign data_address   = {r_addr[ADDR_W-1:2], 2'b00};
  assign data_writedata = swap32((r_state == S_RMW_WR) ? r_merge : r_wdata);

endmodule

// File: tb/tb_mips_mem_access_unit.sv
// Directed bench for mips_mem_access_unit: vector table of single accesses,
// plus reset-during-RMW and back-to-back handshake sequences.
module tb_mips_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  mips_mem_access_unit #(.ADDR_W(32), .RMW_EN(1'b1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_rt         (req_rt),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read, single-cycle write, memory byte order
  logic [31:0] mem [0:15];
  logic        mem_init;
  assign data_readdata = mem[data_address[5:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[1] <= 32'hEFCD_AB89;
    end else if (data_write) begin
      mem[data_address[5:2]] <= data_writedata;
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  int overlap_cnt = 0;

  always @(negedge clk) if (data_read && data_write) overlap_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rt;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rt, output logic [31:0] rdata, output logic err,
                        output int lat, output int rd, output int wr);
    @(negedge clk);
    req_op = op; req_addr = addr; req_wdata = wdata; req_rt = rt; req_valid = 1'b1;
    for (int w = 0; w < 10 && !req_ready; w++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = 0; wr = 0; rdata = 32'h0; err = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (data_read) rd++;
      if (data_write) wr++;
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
  endtask

  logic [3:0]  b_op   [6];
  logic [31:0] b_addr [6];
  logic [31:0] b_data [6];
  logic [31:0] b_exp  [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat, rd, wr;
    int          acc, rsp;
    logic        rdy;

    //            op     addr   wdata         rt            exp_rdata      err  lat rd wr
    vecs[0]  = '{4'd0,  32'h4, 32'h0,        32'h0,        32'hFFFFFF89, 1'b0, 2, 1, 0};
    vecs[1]  = '{4'd1,  32'h4, 32'h0,        32'h0,        32'h00000089, 1'b0, 2, 1, 0};
    vecs[2]  = '{4'd2,  32'h6, 32'h0,        32'h0,        32'hFFFFCDEF, 1'b0, 2, 1, 0};
    vecs[3]  = '{4'd3,  32'h6, 32'h0,        32'h0,        32'h0000CDEF, 1'b0, 2, 1, 0};
    vecs[4]  = '{4'd4,  32'h4, 32'h0,        32'h0,        32'h89ABCDEF, 1'b0, 2, 1, 0};
    vecs[5]  = '{4'd0,  32'h7, 32'h0,        32'h0,        32'hFFFFFFEF, 1'b0, 2, 1, 0};
    vecs[6]  = '{4'd5,  32'h5, 32'h0,        32'h11223344, 32'hABCDEF44, 1'b0, 2, 1, 0};
    vecs[7]  = '{4'd6,  32'h5, 32'h0,        32'h11223344, 32'h112289AB, 1'b0, 2, 1, 0};
    vecs[8]  = '{4'd5,  32'h4, 32'h0,        32'h11223344, 32'h89ABCDEF, 1'b0, 2, 1, 0};
    vecs[9]  = '{4'd6,  32'h7, 32'h0,        32'h11223344, 32'h89ABCDEF, 1'b0, 2, 1, 0};
    vecs[10] = '{4'd8,  32'h5, 32'h000000AA, 32'h0,        32'h00000000, 1'b0, 3, 1, 1};
    vecs[11] = '{4'd4,  32'h4, 32'h0,        32'h0,        32'h89AACDEF, 1'b0, 2, 1, 0};
    vecs[12] = '{4'd9,  32'h6, 32'h00001234, 32'h0,        32'h00000000, 1'b0, 3, 1, 1};
    vecs[13] = '{4'd4,  32'h4, 32'h0,        32'h0,        32'h89AA1234, 1'b0, 2, 1, 0};
    vecs[14] = '{4'd4,  32'h6, 32'h0,        32'h0,        32'h00000000, 1'b1, 1, 0, 0};
    vecs[15] = '{4'd9,  32'h9, 32'h0000FFFF, 32'h0,        32'h00000000, 1'b1, 1, 0, 0};
    vecs[16] = '{4'd7,  32'h4, 32'h0,        32'h0,        32'h00000000, 1'b1, 1, 0, 0};
    vecs[17] = '{4'd4,  32'h4, 32'h0,        32'h0,        32'h89AA1234, 1'b0, 2, 1, 0};
    vecs[18] = '{4'd10, 32'h8, 32'hDEADBEEF, 32'h0,        32'h00000000, 1'b0, 2, 0, 1};

    reset_n = 1'b0; mem_init = 1'b1; req_valid = 1'b0;
    req_op = 4'h0; req_addr = 32'h0; req_wdata = 32'h0; req_rt = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    check("rst_ready",   {31'h0, req_ready},  32'h1);
    check("rst_valid",   {31'h0, resp_valid}, 32'h0);
    check("rst_rdata",   resp_rdata,          32'h0);
    check("rst_err",     {31'h0, resp_err},   32'h0);
    check("rst_addr",    data_address,        32'h0);
    check("rst_strobes", {30'h0, data_read, data_write}, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rt, rdata, err, lat, rd, wr);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      check($sformatf("v%0d_rd", i),  rd, vecs[i].exp_rd);
      check($sformatf("v%0d_wr", i),  wr, vecs[i].exp_wr);
      if (!vecs[i].exp_err) check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
    end
    check("ram_word1", mem[1], 32'h3412AA89);
    check("ram_word2", mem[2], 32'hEFBEADDE);

    // Reset while the SB write-back is on the bus
    @(negedge clk);
    req_op = 4'd8; req_addr = 32'h4; req_wdata = 32'h00000055; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rmw_rd_phase", {31'h0, data_read}, 32'h1);
    @(negedge clk);
    check("rmw_wr_phase", {31'h0, data_write}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("rst_kills_write", {31'h0, data_write}, 32'h0);
    rd = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) rd++;
    end
    check("rst_no_resp", rd, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", {31'h0, req_ready}, 32'h1);
    check("rst_ram_unchanged", mem[1], 32'h3412AA89);

    // Back-to-back: req_valid held high, alternating SW/LW
    b_op[0] = 4'd10; b_addr[0] = 32'h20; b_data[0] = 32'hA0A00001; b_exp[0] = 32'h0;
    b_op[1] = 4'd4;  b_addr[1] = 32'h20; b_data[1] = 32'h0;        b_exp[1] = 32'hA0A00001;
    b_op[2] = 4'd10; b_addr[2] = 32'h24; b_data[2] = 32'hB1B10002; b_exp[2] = 32'h0;
    b_op[3] = 4'd4;  b_addr[3] = 32'h24; b_data[3] = 32'h0;        b_exp[3] = 32'hB1B10002;
    b_op[4] = 4'd10; b_addr[4] = 32'h20; b_data[4] = 32'hC2C20003; b_exp[4] = 32'h0;
    b_op[5] = 4'd4;  b_addr[5] = 32'h20; b_data[5] = 32'h0;        b_exp[5] = 32'hC2C20003;
    acc = 0; rsp = 0;
    for (int c = 0; c < 80 && rsp < 6; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        if (rsp < 6) check($sformatf("b2b_rsp%0d", rsp), resp_rdata, b_exp[rsp]);
        rsp++;
      end
      if (acc < 6) begin
        req_op = b_op[acc]; req_addr = b_addr[acc]; req_wdata = b_data[acc]; req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      rdy = req_ready;
      @(posedge clk);
      if (rdy && req_valid) acc++;
    end
    req_valid = 1'b0;
    check("b2b_accepts", acc, 6);
    check("b2b_responses", rsp, 6);
    check("ram_word9", mem[9], 32'h0200B1B1);
    check("no_rd_wr_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
